// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-outstanding memory port.
// Data wins ties unless the fetch side has waited through STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IfReq,
  input  logic [15:0] IfAddr,
  output logic [15:0] IfRData,
  output logic        IfReady,
  input  logic        DReq,
  input  logic        DWr,
  input  logic [15:0] DAddr,
  input  logic [15:0] DWData,
  output logic [15:0] DRData,
  output logic        DReady,
  output logic        MemReq,
  output logic        MemWr,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  input  logic [15:0] MemRData,
  input  logic        MemAck,
  output logic        Stall
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state, state_n;
  logic       grant_i, grant_d;
  logic [2:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (DReq && !(IfReq && starved)) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end else if (IfReq) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I:  if (MemAck) state_n = DONE_I;
      BUSY_D:  if (MemAck) state_n = DONE_D;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      MemWr      <= 1'b0;
      MemAddr    <= 16'h0000;
      MemWData   <= 16'h0000;
      IfRData    <= 16'h0000;
      DRData     <= 16'h0000;
    end else begin
      state <= state_n;
      if (grant_d) begin
        MemAddr  <= DAddr;
        MemWr    <= DWr;
        MemWData <= DWData;
        // Only data grants that overtake a waiting fetch count toward starvation.
        if (IfReq && !starved) starve_cnt <= starve_cnt + 3'd1;
      end
      if (grant_i) begin
        MemAddr    <= IfAddr;
        MemWr      <= 1'b0;
        starve_cnt <= 3'd0;
      end
      if (state == BUSY_I && MemAck) IfRData <= MemRData;
      if (state == BUSY_D && MemAck && !MemWr) DRData <= MemRData;
    end
  end

  assign MemReq  = (state == BUSY_I) || (state == BUSY_D);
  assign IfReady = (state == DONE_I);
  assign DReady  = (state == DONE_D);
  assign Stall   = (IfReq && !IfReady) || (DReq && !DReady);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random requesters and memory, checked against a
// transaction-level model, plus directed scenarios.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        IfReq = 1'b0, IfReady, DReq = 1'b0, DWr = 1'b0, DReady;
  logic [15:0] IfAddr = '0, IfRData, DAddr = '0, DWData = '0, DRData;
  logic        MemReq, MemWr, MemAck = 1'b0, Stall;
  logic [15:0] MemAddr, MemWData, MemRData = '0;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRData(IfRData), .IfReady(IfReady),
    .DReq(DReq), .DWr(DWr), .DAddr(DAddr), .DWData(DWData), .DRData(DRData), .DReady(DReady),
    .MemReq(MemReq), .MemWr(MemWr), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // stimulus knobs
  int          p_if = 0, p_d = 0, p_spur = 0, p_rst = 0, fixed_lat = 1;
  bit          rst_q = 0, if_go = 0, d_go = 0, spur_go = 0;
  logic [15:0] go_if_addr = '0, go_d_addr = '0, go_d_wdata = '0;
  logic        go_d_wr = 1'b0;

  // environment state
  bit if_pend = 0, d_pend = 0, if_done = 0, d_done = 0;
  int wait_n = 0, lat = 1;
  logic [15:0] mem [logic [15:0]];

  // reference model
  bit          m_busy = 0, m_done = 0, m_win = 0, m_wr = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_if = '0, m_d = '0;
  int          m_starve = 0;
  int          n_ifr = 0, n_dr = 0, cur_len = 0, last_len = 0;
  int          order[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 16'h5A5A) + 16'd7;
  endfunction

  task automatic drive();
    rst = rst_q || (int'($urandom_range(999)) < p_rst);
    if (rst) begin
      IfReq = 0; DReq = 0; if_pend = 0; d_pend = 0;
    end else begin
      if (if_pend && if_done) begin IfReq = 0; if_pend = 0; end
      if (!if_pend && (if_go || int'($urandom_range(99)) < p_if)) begin
        if_pend = 1; IfReq = 1;
        IfAddr = if_go ? go_if_addr : 16'($urandom_range(63));
      end
      if (d_pend && d_done) begin DReq = 0; d_pend = 0; end
      if (!d_pend && (d_go || int'($urandom_range(99)) < p_d)) begin
        d_pend = 1; DReq = 1;
        DWr    = d_go ? go_d_wr    : 1'($urandom_range(1));
        DAddr  = d_go ? go_d_addr  : 16'($urandom_range(31));
        DWData = d_go ? go_d_wdata : 16'($urandom);
      end
    end
    if_done = 0; d_done = 0; if_go = 0; d_go = 0;
    // memory side: random latency 1..3 unless pinned; garbage data when not acking
    MemAck = 0; MemRData = 16'($urandom);
    if (MemReq) begin
      if (wait_n == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 1));
      wait_n++;
      if (wait_n == lat) begin
        MemAck = 1;
        if (MemWr) mem[MemAddr] = MemWData;
        else MemRData = rd(MemAddr);
      end
    end else begin
      wait_n = 0;
      if (spur_go || int'($urandom_range(99)) < p_spur) MemAck = 1;
    end
    spur_go = 0;
  endtask

  task automatic mon();
    bit e_ifr, e_dr;
    e_ifr = m_done && !m_win;
    e_dr  = m_done && m_win;
    chk("MemReq", MemReq, m_busy);
    chk("IfReady", IfReady, e_ifr);
    chk("DReady", DReady, e_dr);
    chk("Stall", Stall, (IfReq && !e_ifr) || (DReq && !e_dr));
    chk("IfRData", IfRData, m_if);
    chk("DRData", DRData, m_d);
    if (m_busy) begin
      chk("MemAddr", MemAddr, m_addr);
      chk("MemWr", MemWr, m_wr);
      if (m_wr) chk("MemWData", MemWData, m_wdata);
    end
    if (IfReady) begin if_done = 1; n_ifr++; order.push_back(0); end
    if (DReady)  begin d_done = 1; n_dr++;  order.push_back(1); end
    if (MemReq) cur_len++;
    else if (cur_len != 0) begin last_len = cur_len; cur_len = 0; end
    // advance the model across the coming edge
    if (rst) begin
      m_busy = 0; m_done = 0; m_starve = 0; m_if = '0; m_d = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (MemAck) begin
        m_busy = 0; m_done = 1;
        if (!m_win) m_if = rd(m_addr);
        else if (!m_wr) m_d = rd(m_addr);
      end
    end else if (IfReq || DReq) begin
      m_busy = 1;
      m_win  = DReq && !(IfReq && m_starve == LIM);
      if (m_win) begin
        m_addr = DAddr; m_wr = DWr; m_wdata = DWData;
        if (IfReq && m_starve < LIM) m_starve++;
      end else begin
        m_addr = IfAddr; m_wr = 0; m_starve = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    mon();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    p_if = 0; p_d = 0; p_spur = 0; p_rst = 0; fixed_lat = 1;
    rst_q = 1; cyc(); rst_q = 0; cyc();
    n_ifr = 0; n_dr = 0; cur_len = 0; last_len = 0; order.delete();
  endtask

  initial begin
    logic [4:0] seq;
    logic [1:0] pair;

    // reset values
    do_reset();
    chk("rst_MemReq", MemReq, 0);
    chk("rst_MemWr", MemWr, 0);
    chk("rst_MemAddr", MemAddr, 16'h0000);
    chk("rst_MemWData", MemWData, 16'h0000);
    chk("rst_IfRData", IfRData, 16'h0000);
    chk("rst_DRData", DRData, 16'h0000);
    chk("rst_ready", {IfReady, DReady}, 2'b00);
    chk("rst_starve", dut.starve_cnt, 0);

    // single fetch, 1-cycle memory
    mem[16'h0010] = 16'hA5C3;
    go_if_addr = 16'h0010; if_go = 1;
    run(8);
    chk("fetch_n", n_ifr, 1);
    chk("fetch_len", last_len, 1);
    chk("fetch_addr", MemAddr, 16'h0010);
    chk("fetch_data", IfRData, 16'hA5C3);
    chk("fetch_dn", n_dr, 0);

    // simultaneous requests: data served first
    do_reset();
    go_if_addr = 16'h0020; go_d_addr = 16'h0200; go_d_wr = 0;
    if_go = 1; d_go = 1;
    run(12);
    pair = (order.size() == 2) ? {order[0][0], order[1][0]} : 2'bxx;
    chk("simul_order", pair, 2'b10);

    // starvation: data reissued back-to-back while fetch waits
    do_reset();
    p_d = 100; go_if_addr = 16'h0030; if_go = 1;
    run(19);
    p_d = 0;
    run(10);
    for (int i = 0; i < 5; i++) seq[4-i] = (order.size() > i) ? order[i][0] : 1'bx;
    chk("starve_seq", seq, 5'b11110);
    chk("starve_cnt", dut.starve_cnt, 0);

    // write with 3-cycle memory latency leaves DRData alone
    do_reset();
    fixed_lat = 3;
    go_d_addr = 16'h0050; go_d_wr = 0; d_go = 1;
    run(8);
    go_d_addr = 16'h0300; go_d_wr = 1; go_d_wdata = 16'h1234; d_go = 1;
    run(10);
    chk("wr_len", last_len, 3);
    chk("wr_n", n_dr, 2);
    chk("wr_MemWr", MemWr, 1);
    chk("wr_MemWData", MemWData, 16'h1234);
    chk("wr_mem", rd(16'h0300), 16'h1234);
    chk("wr_drdata", DRData, (16'h0050 ^ 16'h5A5A) + 16'd7);

    // reset in second busy cycle, late ack afterwards
    do_reset();
    fixed_lat = 5;
    go_d_addr = 16'h0040; go_d_wr = 0; d_go = 1;
    cyc(); cyc();
    rst_q = 1; cyc(); rst_q = 0;
    spur_go = 1; cyc();
    run(4);
    chk("rmid_dn", n_dr, 0);
    chk("rmid_MemReq", MemReq, 0);
    chk("rmid_MemWr", MemWr, 0);
    chk("rmid_MemAddr", MemAddr, 16'h0000);
    chk("rmid_DRData", DRData, 16'h0000);
    chk("rmid_Stall", Stall, 0);

    // spurious ack while idle
    do_reset();
    spur_go = 1; run(1);
    spur_go = 1; run(3);
    chk("spur_ready", n_ifr + n_dr, 0);
    chk("spur_MemReq", MemReq, 0);
    chk("spur_Stall", Stall, 0);

    // random traffic
    do_reset();
    p_if = 35; p_d = 45; p_spur = 10; p_rst = 3; fixed_lat = 0;
    run(4000);
    p_if = 0; p_d = 0; p_spur = 0; p_rst = 0;
    run(20);
    chk("rand_quiet", MemReq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
